// File: rtl/wishbone_manager.sv
// Single-outstanding Wishbone B4 classic-cycle master: one request becomes one registered
// CYC/STB cycle, finished by ACK, ERR or a cycle-count timeout.
module wishbone_manager #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        req_read_i,
   input  logic        req_write_i,
   input  logic [31:0] req_adr_i,
   input  logic [31:0] req_dat_i,
   input  logic [3:0]  req_sel_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);

   typedef enum logic [0:0] {StIdle, StBus} state_e;

   // Counter value at which the last counted STB cycle ends without a response.
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   state_e      state, state_next;
   logic [7:0]  cnt, cnt_next;
   logic        done_next, err_next;
   logic [31:0] rdata_next;
   logic        cyc_next, stb_next, we_next;
   logic [3:0]  sel_next;
   logic [31:0] adr_next, dat_next;

   assign busy_o = (state == StBus);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state     <= StIdle;
         cnt       <= 8'd0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
         rdata_o   <= 32'd0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= 4'd0;
         wbm_adr_o <= 32'd0;
         wbm_dat_o <= 32'd0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         done_o    <= done_next;
         err_o     <= err_next;
         rdata_o   <= rdata_next;
         wbm_cyc_o <= cyc_next;
         wbm_stb_o <= stb_next;
         wbm_we_o  <= we_next;
         wbm_sel_o <= sel_next;
         wbm_adr_o <= adr_next;
         wbm_dat_o <= dat_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      done_next  = 1'b0;
      err_next   = 1'b0;
      rdata_next = rdata_o;
      cyc_next   = wbm_cyc_o;
      stb_next   = wbm_stb_o;
      we_next    = wbm_we_o;
      sel_next   = wbm_sel_o;
      adr_next   = wbm_adr_o;
      dat_next   = wbm_dat_o;

      unique case (state)
         StIdle: begin
            if (req_read_i || req_write_i) begin
               adr_next   = req_adr_i;
               dat_next   = req_dat_i;
               sel_next   = req_sel_i;
               we_next    = req_write_i;
               cyc_next   = 1'b1;
               stb_next   = 1'b1;
               cnt_next   = 8'd0;
               state_next = StBus;
            end
         end
         StBus: begin
            // ACK beats ERR, and any response beats the timeout.
            if (wbm_ack_i) begin
               cyc_next   = 1'b0;
               stb_next   = 1'b0;
               we_next    = 1'b0;
               done_next  = 1'b1;
               state_next = StIdle;
               if (!wbm_we_o) begin
                  rdata_next = wbm_dat_i;
               end
            end else if (wbm_err_i || (cnt == TimeoutLast)) begin
               cyc_next   = 1'b0;
               stb_next   = 1'b0;
               we_next    = 1'b0;
               done_next  = 1'b1;
               err_next   = 1'b1;
               state_next = StIdle;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         default: begin
            state_next = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_wishbone_manager.sv
// Randomized self-checking bench for wishbone_manager with a transaction-level model of
// which edge ends each cycle and how.
module tb_wishbone_manager;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_read = 1'b0, req_write = 1'b0;
   logic [31:0] req_adr = '0, req_dat = '0;
   logic [3:0]  req_sel = '0;
   logic        busy, done, err;
   logic [31:0] rdata;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o;
   logic [31:0] dat_i = '0;
   logic        ack = 1'b0, berr = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] rdata_exp = '0;

   wishbone_manager #(.TIMEOUT(TO)) dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .req_read_i  (req_read),
      .req_write_i (req_write),
      .req_adr_i   (req_adr),
      .req_dat_i   (req_dat),
      .req_sel_i   (req_sel),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err),
      .rdata_o     (rdata),
      .wbm_cyc_o   (cyc),
      .wbm_stb_o   (stb),
      .wbm_we_o    (we),
      .wbm_sel_o   (sel),
      .wbm_adr_o   (adr),
      .wbm_dat_o   (dat_o),
      .wbm_dat_i   (dat_i),
      .wbm_ack_i   (ack),
      .wbm_err_i   (berr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check_val("idle_cyc", cyc, 0);
         check_val("idle_busy", busy, 0);
         check_val("idle_done", done, 0);
      end
   endtask

   // kind: 0 ACK, 1 ERR, 2 ACK+ERR, 3 no response. delay: STB cycle (1-based) of the response.
   task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input int delay,
                          input int kind, input logic [31:0] rdat, input logic noise);
      logic resp, exp_err, we_e;
      int   end_k;
      we_e    = wr;
      resp    = (kind != 3) && (delay <= TO);
      end_k   = resp ? delay : TO;
      exp_err = !resp || (kind == 1);

      req_read = rd; req_write = wr; req_adr = a; req_dat = d; req_sel = s;
      step();
      check_val("acc_cyc", cyc, 1);
      check_val("acc_stb", stb, 1);
      check_val("acc_we", we, we_e);
      check_val("acc_adr", adr, a);
      check_val("acc_dat", dat_o, d);
      check_val("acc_sel", sel, s);
      check_val("acc_busy", busy, 1);
      check_val("acc_done", done, 0);
      check_val("acc_err", err, 0);

      if (noise) begin
         req_read = 1'($urandom); req_write = 1'($urandom);
         req_adr = $urandom; req_dat = $urandom; req_sel = 4'($urandom);
      end else begin
         req_read = 0; req_write = 0;
      end

      for (int k = 1; k <= end_k; k++) begin
         ack   = (k == delay) && (kind == 0 || kind == 2);
         berr  = (k == delay) && (kind == 1 || kind == 2);
         dat_i = (k == delay) ? rdat : $urandom;
         step();
         ack = 0; berr = 0; dat_i = $urandom;
         if (k < end_k) begin
            check_val("bus_stb", stb, 1);
            check_val("bus_cyc", cyc, 1);
            check_val("bus_we", we, we_e);
            check_val("bus_adr", adr, a);
            check_val("bus_done", done, 0);
         end else begin
            req_read = 0; req_write = 0;
            if (!we_e && !exp_err) rdata_exp = rdat;
            check_val("end_cyc", cyc, 0);
            check_val("end_stb", stb, 0);
            check_val("end_we", we, 0);
            check_val("end_busy", busy, 0);
            check_val("end_done", done, 1);
            check_val("end_err", err, exp_err);
            check_val("end_rdata", rdata, rdata_exp);
            check_val("end_adr", adr, a);
            check_val("end_dat", dat_o, d);
            check_val("end_sel", sel, s);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      #2 rst_n = 0;
      #1;
      check_val("rst_cyc", cyc, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_rdata", rdata, 0);
      check_val("rst_adr", adr, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      idle(2);

      // Write, ACK in third STB cycle.
      run_txn(0, 1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 3, 0, 32'h1111_2222, 0);
      idle(1);
      // Read, same-cycle ACK.
      run_txn(1, 0, 32'h3000_0008, 32'h0, 4'hF, 1, 0, 32'hCAFE_F00D, 0);
      idle(1);
      // Both requests, noisy requests during BUS, then back-to-back read held through done.
      run_txn(1, 1, 32'h3000_0010, 32'h5555_AAAA, 4'h3, 2, 0, 32'hDEAD_BEEF, 1);
      run_txn(1, 0, 32'h3000_0014, 32'h0, 4'hC, 2, 0, 32'h0BAD_CAFE, 0);
      idle(1);
      // ERR on a read, then ACK+ERR together.
      run_txn(1, 0, 32'h3000_0020, 32'h0, 4'hF, 2, 1, 32'h7777_7777, 0);
      run_txn(1, 0, 32'h3000_0024, 32'h0, 4'hF, 1, 2, 32'h1234_5678, 0);
      idle(1);
      // Timeout with no response, then ACK in the last counted cycle.
      run_txn(1, 0, 32'h3000_0030, 32'h0, 4'hF, 1, 3, 32'h9999_9999, 0);
      run_txn(1, 0, 32'h3000_0034, 32'h0, 4'hF, TO, 0, 32'h4444_5555, 0);
      idle(1);

      // Reset mid-BUS drops everything and yields no done pulse.
      req_read = 1; req_adr = 32'h3000_0040; req_sel = 4'hF;
      step();
      req_read = 0;
      step();
      check_val("pre_rst_stb", stb, 1);
      #2 rst_n = 0;
      #1;
      rdata_exp = 0;
      check_val("mid_rst_cyc", cyc, 0);
      check_val("mid_rst_stb", stb, 0);
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_done", done, 0);
      check_val("mid_rst_rdata", rdata, 0);
      @(negedge clk);
      rst_n = 1;
      idle(TO + 2);

      for (int t = 0; t < 40; t++) begin
         int op;
         op = $urandom_range(0, 2);
         run_txn(op != 1, op != 0, $urandom, $urandom, 4'($urandom),
                 $urandom_range(1, TO + 2), $urandom_range(0, 3), $urandom,
                 1'($urandom));
         idle($urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
